// File: rtl/tiny_rr_arbiter.sv
// Two-source round-robin arbiter with burst limiting, feeding one registered output stage.
// A source may keep winning contention for up to MAX_BURST accepts before the other source is granted.
module tiny_rr_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [31:0] s0_data,
  input  logic [31:0] s0_addr,
  input  logic        s1_valid,
  output logic        s1_ready,
  input  logic [31:0] s1_data,
  input  logic [31:0] s1_addr,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic [31:0] m_addr,
  output logic        m_src
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  logic        last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        m_valid_q, m_valid_d;
  logic [31:0] m_data_q, m_data_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic        m_src_q, m_src_d;

  logic free;
  logic gnt_vld;
  logic gnt_src;
  logic acc;

  // Grant depends only on valids and arbitration state, never on payload.
  always_comb begin
    free    = !m_valid_q || m_ready;
    gnt_vld = s0_valid || s1_valid;
    gnt_src = 1'b0;
    if (s0_valid && s1_valid) begin
      gnt_src = (cnt_q < MAX_B) ? last_q : !last_q;
    end else if (s1_valid) begin
      gnt_src = 1'b1;
    end
    acc = gnt_vld && free;
  end

  assign s0_ready = gnt_vld && !gnt_src && free;
  assign s1_ready = gnt_vld &&  gnt_src && free;

  always_comb begin
    last_d    = last_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_addr_d  = m_addr_q;
    m_src_d   = m_src_q;
    if (acc) begin
      m_valid_d = 1'b1;
      m_data_d  = gnt_src ? s1_data : s0_data;
      m_addr_d  = gnt_src ? s1_addr : s0_addr;
      m_src_d   = gnt_src;
      if (gnt_src == last_q) begin
        cnt_d = (cnt_q < MAX_B) ? cnt_q + 4'd1 : cnt_q;
      end else begin
        last_d = gnt_src;
        cnt_d  = 4'd1;
      end
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q    <= 1'b0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_addr_q  <= '0;
      m_src_q   <= 1'b0;
    end else begin
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_addr_q  <= m_addr_d;
      m_src_q   <= m_src_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_addr  = m_addr_q;
  assign m_src   = m_src_q;

endmodule

// File: tb/tb_tiny_rr_arbiter.sv
// Directed bench for tiny_rr_arbiter: one instance with MAX_BURST=4, one with MAX_BURST=1.
module tb_tiny_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s0_valid, s1_valid;
  logic [31:0] s0_data, s0_addr, s1_data, s1_addr;
  logic        m_ready_a, m_ready_b;

  logic        a_s0_ready, a_s1_ready, a_m_valid, a_m_src;
  logic [31:0] a_m_data, a_m_addr;
  logic        b_s0_ready, b_s1_ready, b_m_valid, b_m_src;
  logic [31:0] b_m_data, b_m_addr;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  tiny_rr_arbiter #(.MAX_BURST(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(a_s0_ready), .s0_data(s0_data), .s0_addr(s0_addr),
    .s1_valid(s1_valid), .s1_ready(a_s1_ready), .s1_data(s1_data), .s1_addr(s1_addr),
    .m_valid(a_m_valid), .m_ready(m_ready_a), .m_data(a_m_data), .m_addr(a_m_addr),
    .m_src(a_m_src)
  );

  tiny_rr_arbiter #(.MAX_BURST(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(b_s0_ready), .s0_data(s0_data), .s0_addr(s0_addr),
    .s1_valid(s1_valid), .s1_ready(b_s1_ready), .s1_data(s1_data), .s1_addr(s1_addr),
    .m_valid(b_m_valid), .m_ready(m_ready_b), .m_data(b_m_data), .m_addr(b_m_addr),
    .m_src(b_m_src)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    s0_valid = 1'b0; s1_valid = 1'b0;
    s0_data = 32'h100; s0_addr = 32'h10;
    s1_data = 32'h200; s1_addr = 32'h20;
    m_ready_a = 1'b1; m_ready_b = 1'b1;

    // reset state
    step(); step();
    chk("rst_m_valid", 32'(a_m_valid), 32'd0);
    chk("rst_m_data",  a_m_data, 32'd0);
    chk("rst_m_addr",  a_m_addr, 32'd0);
    chk("rst_m_src",   32'(a_m_src), 32'd0);
    rst_n = 1'b1;

    // first contention: s0 wins, output one cycle after accept
    s0_valid = 1'b1; s1_valid = 1'b1;
    #1;
    chk("first_s0_ready", 32'(a_s0_ready), 32'd1);
    chk("first_s1_ready", 32'(a_s1_ready), 32'd0);
    chk("first_m_valid_pre", 32'(a_m_valid), 32'd0);
    step();
    chk("first_m_valid", 32'(a_m_valid), 32'd1);
    chk("first_m_addr",  a_m_addr, 32'h10);
    chk("first_m_src",   32'(a_m_src), 32'd0);

    // burst pattern 0,0,0,0,1,1,1,1,0,0 with no idle cycles
    for (int i = 1; i < 10; i++) begin
      logic exp_src;
      exp_src = (i >= 4 && i < 8);
      step();
      chk($sformatf("burst_valid_%0d", i), 32'(a_m_valid), 32'd1);
      chk($sformatf("burst_src_%0d", i), 32'(a_m_src), 32'(exp_src));
      chk($sformatf("burst_addr_%0d", i), a_m_addr, exp_src ? 32'h20 : 32'h10);
    end

    // idle drains output but holds payload
    s0_valid = 1'b0; s1_valid = 1'b0;
    step();
    chk("drain_m_valid", 32'(a_m_valid), 32'd0);
    chk("drain_m_addr",  a_m_addr, 32'h10);
    chk("drain_m_src",   32'(a_m_src), 32'd0);

    // backpressure stability
    s0_valid = 1'b1; s0_data = 32'hA5A5A5A5; s0_addr = 32'h30; m_ready_a = 1'b0;
    #1;
    chk("bp_accept_ready", 32'(a_s0_ready), 32'd1);
    step();
    chk("bp_m_valid0", 32'(a_m_valid), 32'd1);
    chk("bp_m_data0",  a_m_data, 32'hA5A5A5A5);
    s0_data = 32'h11111111; s1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_s0_ready_%0d", i), 32'(a_s0_ready), 32'd0);
      chk($sformatf("bp_s1_ready_%0d", i), 32'(a_s1_ready), 32'd0);
      step();
      chk($sformatf("bp_m_valid_%0d", i), 32'(a_m_valid), 32'd1);
      chk($sformatf("bp_m_data_%0d", i), a_m_data, 32'hA5A5A5A5);
      chk($sformatf("bp_m_src_%0d", i), 32'(a_m_src), 32'd0);
    end
    m_ready_a = 1'b1;
    #1;
    chk("bp_release_s0_ready", 32'(a_s0_ready), 32'd1);
    chk("bp_release_s1_ready", 32'(a_s1_ready), 32'd0);
    step();
    chk("bp_next_data", a_m_data, 32'h11111111);

    // s1 alone for 10 beats, then s0 joins and must win
    s0_valid = 1'b0; s1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s1_data = 32'h5000 + 32'(i);
      step();
      chk($sformatf("solo_src_%0d", i), 32'(a_m_src), 32'd1);
      chk($sformatf("solo_data_%0d", i), a_m_data, 32'h5000 + 32'(i));
    end
    s0_valid = 1'b1; s0_data = 32'h600;
    #1;
    chk("sat_s0_ready", 32'(a_s0_ready), 32'd1);
    chk("sat_s1_ready", 32'(a_s1_ready), 32'd0);
    step();
    chk("sat_src",  32'(a_m_src), 32'd0);
    chk("sat_data", a_m_data, 32'h600);

    // reset while a beat is held, with last == 1 beforehand
    s0_valid = 1'b0; s1_data = 32'h700;
    step();
    chk("pre_rst_src", 32'(a_m_src), 32'd1);
    m_ready_a = 1'b0; s1_valid = 1'b0;
    step();
    chk("held_valid", 32'(a_m_valid), 32'd1);
    chk("held_data",  a_m_data, 32'h700);
    rst_n = 1'b0; s1_valid = 1'b1;
    step();
    chk("midrst_m_valid", 32'(a_m_valid), 32'd0);
    chk("midrst_m_data",  a_m_data, 32'd0);
    chk("midrst_m_addr",  a_m_addr, 32'd0);
    chk("midrst_m_src",   32'(a_m_src), 32'd0);
    rst_n = 1'b1; s0_valid = 1'b1; m_ready_a = 1'b1;
    #1;
    chk("postrst_s0_ready", 32'(a_s0_ready), 32'd1);
    chk("postrst_s1_ready", 32'(a_s1_ready), 32'd0);
    step();
    chk("postrst_src", 32'(a_m_src), 32'd0);

    // MAX_BURST=1: strict alternation with toggling m_ready
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    s0_valid = 1'b1; s1_valid = 1'b1;
    s0_addr = 32'hB0; s1_addr = 32'hB1;
    for (int k = 0; k < 4; k++) begin
      logic exp_src;
      exp_src = k[0];
      m_ready_b = 1'b1;
      step();
      chk($sformatf("alt_valid_%0d", k), 32'(b_m_valid), 32'd1);
      chk($sformatf("alt_src_%0d", k), 32'(b_m_src), 32'(exp_src));
      m_ready_b = 1'b0;
      #1;
      chk($sformatf("alt_hold_s0r_%0d", k), 32'(b_s0_ready), 32'd0);
      chk($sformatf("alt_hold_s1r_%0d", k), 32'(b_s1_ready), 32'd0);
      step();
      chk($sformatf("alt_hold_valid_%0d", k), 32'(b_m_valid), 32'd1);
      chk($sformatf("alt_hold_src_%0d", k), 32'(b_m_src), 32'(exp_src));
      chk($sformatf("alt_hold_addr_%0d", k), b_m_addr, exp_src ? 32'hB1 : 32'hB0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
